// File: rtl/shift_reg_out.sv
// -----------------------------------------------------------------------------
// shift_reg_out
//
// Mirrors a parallel data word onto an external 74HC595-style serial-in /
// parallel-out register chain. While enabled, any difference between in_data
// and the last word transmitted starts a transfer. A forced transfer after
// reset initialises the external register. Each transfer shifts the word out
// with a divided serial clock, then pulses the storage latch.
//
// Ports:
//   in_clk      main clock; all logic runs on its rising edge
//   in_rst      asynchronous active-low reset
//   in_enable   1 = transfers may start; an in-flight transfer always completes
//   in_data     parallel word to mirror (DATA_BITS wide)
//   out_serial  serial data to the register SER pin
//   out_sclk    shift clock to SRCLK; the register samples on its rising edge
//   out_latch   storage latch to RCLK; its rising edge updates the outputs
//   out_busy    high for every non-idle cycle of a transfer
//   out_done    one-cycle pulse on the final cycle of a transfer
// -----------------------------------------------------------------------------
module shift_reg_out #(
    parameter int unsigned MAIN_HZ   = 50_000_000,
    parameter int unsigned SERIAL_HZ = 1_000_000,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_enable,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_serial,
    output logic                 out_sclk,
    output logic                 out_latch,
    output logic                 out_busy,
    output logic                 out_done
);

    // Half-period of the serial clock in main clocks, never below one.
    localparam int unsigned DIV_RAW = MAIN_HZ / SERIAL_HZ / 2;
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned WAIT_W  = $clog2(DIV) + 1;
    localparam int unsigned BIT_W   = $clog2(DATA_BITS) + 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SHIFT_LOW  = 2'd1,
        ST_SHIFT_HIGH = 2'd2,
        ST_LATCH      = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [WAIT_W-1:0]     wait_q;
    logic [WAIT_W-1:0]     wait_d;
    logic [BIT_W-1:0]      bit_q;
    logic [BIT_W-1:0]      bit_d;
    logic [DATA_BITS-1:0]  shift_q;
    logic [DATA_BITS-1:0]  shift_d;
    logic [DATA_BITS-1:0]  last_q;
    logic [DATA_BITS-1:0]  last_d;
    logic                  first_q;
    logic                  first_d;

    logic                  phase_end;
    logic                  start;
    logic [DATA_BITS-1:0]  shift_adv;
    logic                  tx_bit_d;

    logic                  serial_d;
    logic                  sclk_d;
    logic                  latch_d;
    logic                  busy_d;
    logic                  done_d;

    // Every timed phase lasts exactly DIV clocks.
    assign phase_end = (wait_q == WAIT_LAST);

    // A new transfer is due when enabled and the word differs from the last
    // one sent, or unconditionally once after reset.
    assign start = in_enable && ((in_data != last_q) || first_q);

    // Move the next bit toward the output end of the shift register.
    assign shift_adv = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

    // FSM state and datapath registers.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            last_q  <= '0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            first_q <= first_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        first_d = first_q;

        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (start) begin
                    // Freeze the word; later in_data changes wait for Idle.
                    shift_d = in_data;
                    last_d  = in_data;
                    first_d = 1'b0;
                    bit_d   = '0;
                    state_d = ST_SHIFT_LOW;
                end
            end

            ST_SHIFT_LOW: begin
                if (phase_end) begin
                    wait_d  = '0;
                    state_d = ST_SHIFT_HIGH;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_SHIFT_HIGH: begin
                if (phase_end) begin
                    wait_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_LATCH;
                    end else begin
                        shift_d = shift_adv;
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = ST_SHIFT_LOW;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_LATCH: begin
                if (phase_end) begin
                    wait_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            default: begin
                wait_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so the
    // registered pins line up exactly with the state they describe.
    always_comb begin
        tx_bit_d = (MSB_FIRST != 0) ? shift_d[DATA_BITS-1] : shift_d[0];
        serial_d = 1'b0;
        sclk_d   = 1'b0;
        latch_d  = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        done_d   = 1'b0;

        case (state_d)
            ST_SHIFT_LOW: begin
                serial_d = tx_bit_d;
            end
            ST_SHIFT_HIGH: begin
                // shift_d only advances on leaving this phase, so the bit holds.
                serial_d = tx_bit_d;
                sclk_d   = 1'b1;
            end
            ST_LATCH: begin
                latch_d = 1'b1;
                done_d  = (wait_d == WAIT_LAST);
            end
            default: begin
                serial_d = 1'b0;
            end
        endcase
    end

    // Glitch-free registered pins; reset clears them asynchronously.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            out_serial <= 1'b0;
            out_sclk   <= 1'b0;
            out_latch  <= 1'b0;
            out_busy   <= 1'b0;
            out_done   <= 1'b0;
        end else begin
            out_serial <= serial_d;
            out_sclk   <= sclk_d;
            out_latch  <= latch_d;
            out_busy   <= busy_d;
            out_done   <= done_d;
        end
    end

endmodule

// File: tb/tb_shift_reg_out.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_out
//
// Bench for shift_reg_out with DIV=2 and DATA_BITS=8. It uses one MSB-first
// instance and one LSB-first instance. Monitors on the falling clock edge
// record the sclk rises, the data seen at each rise, and the latch, done and
// busy activity. Expected words and durations come from the transfer rules
// (DIV=2 -> 34 busy cycles, 8 rises, 2 latch cycles).
// -----------------------------------------------------------------------------
module tb_shift_reg_out;

    localparam int DW = 8;

    logic          in_clk    = 1'b0;
    logic          in_rst    = 1'b0;
    logic          in_enable = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_serial;
    logic          out_sclk;
    logic          out_latch;
    logic          out_busy;
    logic          out_done;

    logic          lsb_enable = 1'b0;
    logic [DW-1:0] lsb_data   = '0;
    logic          lsb_serial;
    logic          lsb_sclk;
    logic          lsb_latch;
    logic          lsb_busy;
    logic          lsb_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 in_clk = ~in_clk;

    shift_reg_out #(
        .MAIN_HZ(8), .SERIAL_HZ(2), .DATA_BITS(DW), .MSB_FIRST(1)
    ) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_enable(in_enable), .in_data(in_data),
        .out_serial(out_serial), .out_sclk(out_sclk), .out_latch(out_latch),
        .out_busy(out_busy), .out_done(out_done)
    );

    shift_reg_out #(
        .MAIN_HZ(8), .SERIAL_HZ(2), .DATA_BITS(DW), .MSB_FIRST(0)
    ) dut_lsb (
        .in_clk(in_clk), .in_rst(in_rst), .in_enable(lsb_enable), .in_data(lsb_data),
        .out_serial(lsb_serial), .out_sclk(lsb_sclk), .out_latch(lsb_latch),
        .out_busy(lsb_busy), .out_done(lsb_done)
    );

    // Activity monitor for the MSB-first instance.
    int   sclk_rises = 0, latch_rises = 0, latch_cycles = 0, latch_rise_at = -1;
    int   done_rises = 0, done_cycles = 0, busy_cycles = 0;
    int   overlap_errs = 0, serial_errs = 0;
    logic bits_q[$];
    logic prev_sclk = 1'b0, prev_latch = 1'b0, prev_serial = 1'b0, prev_done = 1'b0;

    always @(negedge in_clk) begin
        if (out_sclk && !prev_sclk) begin
            sclk_rises++;
            bits_q.push_back(out_serial);
        end
        if (out_sclk && prev_sclk && (out_serial !== prev_serial)) serial_errs++;
        if (out_latch && !prev_latch) begin
            latch_rises++;
            latch_rise_at = sclk_rises;
        end
        if (out_latch) latch_cycles++;
        if (out_latch && out_sclk) overlap_errs++;
        if (out_done && !prev_done) done_rises++;
        if (out_done) done_cycles++;
        if (out_busy) busy_cycles++;
        prev_sclk   = out_sclk;
        prev_latch  = out_latch;
        prev_serial = out_serial;
        prev_done   = out_done;
    end

    // Activity monitor for the LSB-first instance.
    int   lsb_latch_rises = 0, lsb_done_rises = 0, lsb_busy_cycles = 0;
    logic lsb_q[$];
    logic lsb_prev_sclk = 1'b0, lsb_prev_latch = 1'b0, lsb_prev_done = 1'b0;

    always @(negedge in_clk) begin
        if (lsb_sclk && !lsb_prev_sclk) lsb_q.push_back(lsb_serial);
        if (lsb_latch && !lsb_prev_latch) lsb_latch_rises++;
        if (lsb_done && !lsb_prev_done) lsb_done_rises++;
        if (lsb_busy) lsb_busy_cycles++;
        lsb_prev_sclk  = lsb_sclk;
        lsb_prev_latch = lsb_latch;
        lsb_prev_done  = lsb_done;
    end

    // First bit received is the word's MSB.
    function automatic logic [DW-1:0] msb_word(input int start);
        logic [DW-1:0] w;
        w = 'x;
        if (bits_q.size() >= start + DW)
            for (int i = 0; i < DW; i++) w[DW-1-i] = bits_q[start+i];
        return w;
    endfunction

    // First bit received is the word's LSB.
    function automatic logic [DW-1:0] lsb_word(input int start);
        logic [DW-1:0] w;
        w = 'x;
        if (lsb_q.size() >= start + DW)
            for (int i = 0; i < DW; i++) w[i] = lsb_q[start+i];
        return w;
    endfunction

    task automatic step();
        @(negedge in_clk);
        #1;
    endtask

    // Waits (bounded) until done_rises moves past base.
    task automatic wait_done(input int base, output bit got);
        int n;
        n = 0;
        while (done_rises == base && n < 200) begin
            step();
            n++;
        end
        got = (done_rises != base);
    endtask

    task automatic test_reset();
        int b_r, b_bits, b_b, b_l, b_lc, b_d, b_dc;
        bit got;
        in_rst = 1'b0; in_enable = 1'b1; in_data = 8'h00;
        repeat (3) step();
        n_checks++;
        if ({out_serial, out_sclk, out_latch, out_busy, out_done} !== 5'b0)
            $display("FAIL reset_outputs: got %b expected 00000",
                     {out_serial, out_sclk, out_latch, out_busy, out_done});
        else n_pass++;

        b_r = sclk_rises; b_bits = bits_q.size(); b_b = busy_cycles;
        b_l = latch_rises; b_lc = latch_cycles; b_d = done_rises; b_dc = done_cycles;
        in_rst = 1'b1;
        wait_done(b_d, got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL first_flag_done: got %0b expected 1", got); else n_pass++;
        n_checks++;
        if (sclk_rises - b_r != 8) $display("FAIL first_rises: got %0d expected 8", sclk_rises - b_r); else n_pass++;
        n_checks++;
        if (msb_word(b_bits) !== 8'h00) $display("FAIL first_word: got %h expected 00", msb_word(b_bits)); else n_pass++;
        n_checks++;
        if (busy_cycles - b_b != 34) $display("FAIL busy_len: got %0d expected 34", busy_cycles - b_b); else n_pass++;
        n_checks++;
        if (latch_cycles - b_lc != 2) $display("FAIL latch_len: got %0d expected 2", latch_cycles - b_lc); else n_pass++;
        n_checks++;
        if (latch_rises - b_l != 1) $display("FAIL latch_count: got %0d expected 1", latch_rises - b_l); else n_pass++;
        n_checks++;
        if (done_cycles - b_dc != 1) $display("FAIL done_width: got %0d expected 1", done_cycles - b_dc); else n_pass++;

        repeat (40) step();
        n_checks++;
        if (sclk_rises - b_r != 8 || done_rises - b_d != 1)
            $display("FAIL idle_quiet: got rises=%0d dones=%0d expected 8 1",
                     sclk_rises - b_r, done_rises - b_d);
        else n_pass++;
    endtask

    task automatic test_change_and_drop();
        int b_r, b_bits, b_d, n;
        logic busy1;
        bit got;
        b_r = sclk_rises; b_bits = bits_q.size(); b_d = done_rises;
        busy1 = 1'b0;
        in_data = 8'hA5;
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) busy1 = out_busy;
        end while (!out_sclk && n < 20);
        n_checks++;
        if (n != 3) $display("FAIL first_rise_latency: got %0d expected 3", n); else n_pass++;
        n_checks++;
        if (busy1 !== 1'b1) $display("FAIL busy_start: got %b expected 1", busy1); else n_pass++;

        in_data = 8'h3C;
        repeat (3) step();
        in_data = 8'h55;
        wait_done(b_d, got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL a5_done: got %0b expected 1", got); else n_pass++;
        n_checks++;
        if (msb_word(b_bits) !== 8'hA5) $display("FAIL a5_word: got %h expected a5", msb_word(b_bits)); else n_pass++;
        n_checks++;
        if (latch_rise_at != b_r + 8)
            $display("FAIL latch_after_8th: got %0d expected %0d", latch_rise_at, b_r + 8);
        else n_pass++;

        wait_done(b_d + 1, got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL latest_done: got %0b expected 1", got); else n_pass++;
        n_checks++;
        if (msb_word(b_bits + 8) !== 8'h55)
            $display("FAIL latest_word: got %h expected 55", msb_word(b_bits + 8));
        else n_pass++;
        repeat (40) step();
        n_checks++;
        if (done_rises - b_d != 2 || sclk_rises - b_r != 16)
            $display("FAIL dropped_value: got dones=%0d rises=%0d expected 2 16",
                     done_rises - b_d, sclk_rises - b_r);
        else n_pass++;
    endtask

    task automatic test_lsb_first();
        int b, b_l, b_d, b_b, n;
        b = lsb_q.size(); b_l = lsb_latch_rises; b_d = lsb_done_rises; b_b = lsb_busy_cycles;
        lsb_data = 8'h01;
        lsb_enable = 1'b1;
        n = 0;
        while (lsb_done_rises == b_d && n < 200) begin
            step();
            n++;
        end
        n_checks++;
        if (lsb_done_rises == b_d) $display("FAIL lsb_done: got timeout expected done"); else n_pass++;
        n_checks++;
        if (lsb_q.size() - b != 8) $display("FAIL lsb_rises: got %0d expected 8", lsb_q.size() - b); else n_pass++;
        n_checks++;
        if (lsb_word(b) !== 8'h01) $display("FAIL lsb_word: got %h expected 01", lsb_word(b)); else n_pass++;
        n_checks++;
        if (lsb_latch_rises - b_l != 1 || lsb_busy_cycles - b_b != 34)
            $display("FAIL lsb_latch_busy: got latch=%0d busy=%0d expected 1 34",
                     lsb_latch_rises - b_l, lsb_busy_cycles - b_b);
        else n_pass++;
    endtask

    task automatic test_enable();
        int b_r, b_l, b_b, b_bits, b_d;
        bit got;
        b_r = sclk_rises; b_l = latch_rises; b_b = busy_cycles; b_bits = bits_q.size(); b_d = done_rises;
        in_enable = 1'b0;
        in_data   = 8'h96;
        repeat (20) step();
        n_checks++;
        if ((sclk_rises - b_r) + (latch_rises - b_l) + (busy_cycles - b_b) != 0)
            $display("FAIL disabled_quiet: got rises=%0d latches=%0d busy=%0d expected 0 0 0",
                     sclk_rises - b_r, latch_rises - b_l, busy_cycles - b_b);
        else n_pass++;

        in_enable = 1'b1;
        step();
        n_checks++;
        if (out_busy !== 1'b1) $display("FAIL enable_start: got %b expected 1", out_busy); else n_pass++;
        step();
        in_enable = 1'b0;
        wait_done(b_d, got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL enable_drop_done: got %0b expected 1", got); else n_pass++;
        n_checks++;
        if (msb_word(b_bits) !== 8'h96) $display("FAIL enable_word: got %h expected 96", msb_word(b_bits)); else n_pass++;

        repeat (20) step();
        in_enable = 1'b1;
        repeat (40) step();
        n_checks++;
        if (done_rises - b_d != 1) $display("FAIL unchanged_quiet: got %0d expected 1", done_rises - b_d); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int b_r, b_bits, b_d, n;
        bit got;
        b_r = sclk_rises;
        in_data = 8'hC3;
        n = 0;
        while (sclk_rises != b_r + 4 && n < 200) begin
            step();
            n++;
        end
        n_checks++;
        if (sclk_rises != b_r + 4) $display("FAIL mid_reach: got %0d expected %0d", sclk_rises, b_r + 4); else n_pass++;
        in_rst = 1'b0;
        #1;
        n_checks++;
        if ({out_serial, out_sclk, out_latch, out_busy, out_done} !== 5'b0)
            $display("FAIL mid_reset_outputs: got %b expected 00000",
                     {out_serial, out_sclk, out_latch, out_busy, out_done});
        else n_pass++;

        step();
        b_r = sclk_rises; b_bits = bits_q.size(); b_d = done_rises;
        in_rst = 1'b1;
        wait_done(b_d, got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL refresh_done: got %0b expected 1", got); else n_pass++;
        n_checks++;
        if (sclk_rises - b_r != 8) $display("FAIL refresh_rises: got %0d expected 8", sclk_rises - b_r); else n_pass++;
        n_checks++;
        if (msb_word(b_bits) !== 8'hC3) $display("FAIL refresh_word: got %h expected c3", msb_word(b_bits)); else n_pass++;
    endtask

    task automatic test_random();
        logic [DW-1:0] cur, nxt;
        int b_bits, b_d;
        bit got;
        cur = DW'($urandom);
        if (cur == 8'hC3) cur = ~cur;
        in_data = cur;
        for (int it = 0; it < 6; it++) begin
            b_bits = bits_q.size(); b_d = done_rises;
            repeat (3) step();
            // Intermediate values while busy must never reach the register.
            repeat (3) begin
                repeat ($urandom_range(1, 6)) step();
                in_data = DW'($urandom);
            end
            wait_done(b_d, got);
            n_checks++;
            if (got !== 1'b1 || msb_word(b_bits) !== cur)
                $display("FAIL rand_word[%0d]: got done=%0b word=%h expected 1 %h",
                         it, got, msb_word(b_bits), cur);
            else n_pass++;
            nxt = DW'($urandom);
            if (nxt == cur) nxt = cur ^ 8'h01;
            in_data = nxt;
            cur = nxt;
        end
        b_bits = bits_q.size(); b_d = done_rises;
        wait_done(b_d, got);
        n_checks++;
        if (got !== 1'b1 || msb_word(b_bits) !== cur)
            $display("FAIL rand_final: got done=%0b word=%h expected 1 %h", got, msb_word(b_bits), cur);
        else n_pass++;
        repeat (40) step();
        n_checks++;
        if (done_rises - b_d != 1) $display("FAIL rand_quiet: got %0d expected 1", done_rises - b_d); else n_pass++;
    endtask

    task automatic test_pin_integrity();
        n_checks++;
        if (overlap_errs != 0) $display("FAIL latch_sclk_overlap: got %0d expected 0", overlap_errs); else n_pass++;
        n_checks++;
        if (serial_errs != 0) $display("FAIL serial_while_high: got %0d expected 0", serial_errs); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_change_and_drop();
        test_lsb_first();
        test_enable();
        test_reset_mid();
        test_random();
        test_pin_integrity();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
